dom_sbox_scheduler: RTL and testbench
=====================================

Name: dom_sbox_scheduler

Overview:
- Sequences the single shared, pipelined DOM-masked composite-field S-box (GF(2^4)/GF(2^2) datapath) between two requesters: round-state SubBytes (16 bytes) and key-schedule SubWord (4 bytes).
- Issues one byte per cycle, gated on fresh-randomness availability. Tracks in-flight bytes through a tag delay line and emits write-back strobes aligned with S-box outputs.
- Sits between the AES round controller and the shared S-box instance.

Parameters:
- SBOX_LAT, 4: S-box pipeline latency in cycles from input valid to output valid (>=1).
- N_STATE, 16: bytes per state request.
- N_KEY, 4: bytes per key-schedule request.
- IDX_W, 4: byte-index width; must satisfy 2^IDX_W >= max(N_STATE, N_KEY).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  2  bit0 = state SubBytes request, bit1 = key SubWord request; level, sampled in IDLE only.
- done_o  out  2  one-cycle completion pulse per requester.
- busy_o  out  1  high in every state other than IDLE.
- rnd_valid_i  in  1  fresh mask randomness available this cycle.
- rnd_ready_o  out  1  randomness consumed this cycle; equals sbox_in_valid_o.
- sbox_in_valid_o  out  1  byte presented to the S-box this cycle.
- sbox_in_idx_o  out  IDX_W  index of the byte presented; used to select the input share mux.
- sbox_in_sel_o  out  1  0 = state, 1 = key.
- wb_valid_o  out  1  S-box output valid; write back this cycle.
- wb_idx_o  out  IDX_W  destination byte index.
- wb_sel_o  out  1  destination requester.

Behaviour:
- Reset (asynchronous, rst_n low): FSM to IDLE; all outputs 0; issue counter 0; delay line cleared.
- Reset mid-operation: in-flight bytes are discarded. No write-back strobe or done pulse for them.
- FSM states:
  - IDLE -> ISSUE when req_i != 0. Fixed priority: bit1 (key) wins over bit0. The grant latches sel and count N = N_KEY or N_STATE. No pre-emption once granted.
  - ISSUE: each cycle with rnd_valid_i=1, assert sbox_in_valid_o and rnd_ready_o, drive sbox_in_idx_o = counter, then increment the counter. With rnd_valid_i=0, the cycle is a bubble: no issue, counter holds. Issuing index N-1 transitions to DRAIN.
  - DRAIN: waits until the last tagged byte exits the delay line. The cycle with the last wb_valid_o transitions to DONE.
  - DONE: done_o[sel]=1 for exactly one cycle, then IDLE.
- Index order is ascending, 0..N-1, contiguous; stalls never reorder bytes.
- Delay line: SBOX_LAT stages of {valid, idx, sel}, shifted every cycle.
  - Stage 0 loads the issue signals.
  - wb_* are driven from the final stage, so wb_valid_o rises exactly SBOX_LAT cycles after the matching sbox_in_valid_o.
- The S-box pipeline is free-running. Bubbles propagate as wb_valid_o=0.
- Request bits are sampled only in IDLE.
  - A request dropped after grant is ignored; the operation completes.
  - A request still high when IDLE is re-entered is granted that cycle. If both are pending after key completes, state is served next.
- Timing with no stalls, N=16, SBOX_LAT=4, req seen in IDLE at cycle 0:
  - issues at cycles 1..16
  - write-backs at cycles 5..20
  - done_o[0] at cycle 21
  - IDLE at cycle 22
- sbox_in_* and wb_* are never valid for bytes belonging to two different grants at once: DRAIN guarantees the pipeline is empty before the next grant.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, ISSUE, DRAIN, DONE)
  - requester select constants SEL_STATE=0, SEL_KEY=1
  - byte-count constants N_STATE and N_KEY
  - default S-box latency, shared with the S-box top so the two cannot diverge
- One sub-module, sbox_tag_pipe: parameterised SBOX_LAT-deep delay line of {valid, idx, sel} with async active-low clear. It is reusable for any pipelined masked GF datapath stage.

Test Plan:
- State request, rnd_valid_i held at 1, SBOX_LAT=4 -> sbox_in_idx_o 0..15 on cycles 1..16; wb_idx_o 0..15 on cycles 5..20; done_o=2'b01 on cycle 21 only; busy_o high for cycles 1..21.
- Both req bits raised in the same cycle -> key served first (4 issues, done_o=2'b10), then state served from the next IDLE cycle (done_o=2'b01). No overlapping wb_sel_o values.
- Key request, rnd_valid_i low on cycles 2 and 3 -> issues on cycles 1, 4, 5, 6 with idx 0, 1, 2, 3; wb_valid_o on cycles 5, 8, 9, 10; done_o=2'b10 on cycle 11; rnd_ready_o never high while rnd_valid_i is low.
- rst_n pulsed low at cycle 8 of a state operation -> all outputs 0 immediately (asynchronously). No wb_valid_o or done_o afterwards until a new request arrives.
- req_i[0] dropped at cycle 3 of an operation -> operation completes with all 16 write-backs and done_o[0]. No re-grant.
- SBOX_LAT=1 build -> wb_valid_o follows each issue by exactly 1 cycle; done_o on cycle 18 for a state request with no stalls.

Source files
------------

// File: rtl/dom_sbox_scheduler_pkg.sv
// Shared constants and types for the masked S-box scheduler and the S-box top.
package dom_sbox_scheduler_pkg;

  localparam int SBOX_LAT_DEFAULT = 4;
  localparam int N_STATE_BYTES    = 16;
  localparam int N_KEY_BYTES      = 4;
  localparam int IDX_W_DEFAULT    = 4;

  localparam logic SEL_STATE = 1'b0;
  localparam logic SEL_KEY   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/dom_sbox_scheduler_tag_pipe.sv
// Fixed-depth delay line of {valid, idx, sel} tags that tracks bytes through a
// free-running pipelined datapath; async clear drops everything in flight.
module sbox_tag_pipe #(
  parameter int LAT   = 4,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [IDX_W-1:0] in_idx_i,
  input  logic             in_sel_i,
  output logic             out_valid_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_sel_o
);

  logic             vld_q [LAT];
  logic [IDX_W-1:0] idx_q [LAT];
  logic             sel_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
        idx_q[i] <= '0;
        sel_q[i] <= 1'b0;
      end
    end else begin
      vld_q[0] <= in_valid_i;
      idx_q[0] <= in_idx_i;
      sel_q[0] <= in_sel_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
        sel_q[i] <= sel_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[LAT-1];
  assign out_idx_o   = idx_q[LAT-1];
  assign out_sel_o   = sel_q[LAT-1];

endmodule

// File: rtl/dom_sbox_scheduler.sv
// Arbitrates the shared masked S-box between SubBytes and SubWord, issuing one
// byte per cycle when fresh randomness is present and aligning write-backs.
//
// state    | meaning
// IDLE     | waiting for a request; key has priority over state
// ISSUE    | one byte per cycle with rnd_valid_i, ascending index
// DRAIN    | all bytes issued, waiting for the last one to leave the pipe
// DONE     | one-cycle completion pulse for the granted requester
module dom_sbox_scheduler
  import dom_sbox_scheduler_pkg::*;
#(
  parameter int SBOX_LAT = SBOX_LAT_DEFAULT,
  parameter int N_STATE  = N_STATE_BYTES,
  parameter int N_KEY    = N_KEY_BYTES,
  parameter int IDX_W    = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_i,
  output logic [1:0]       done_o,
  output logic             busy_o,
  input  logic             rnd_valid_i,
  output logic             rnd_ready_o,
  output logic             sbox_in_valid_o,
  output logic [IDX_W-1:0] sbox_in_idx_o,
  output logic             sbox_in_sel_o,
  output logic             wb_valid_o,
  output logic [IDX_W-1:0] wb_idx_o,
  output logic             wb_sel_o
);

  localparam logic [IDX_W-1:0] STATE_LAST = IDX_W'(N_STATE - 1);
  localparam logic [IDX_W-1:0] KEY_LAST   = IDX_W'(N_KEY - 1);

  sched_state_e     state_q, state_d;
  logic             sel_q, sel_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             issue;
  logic [1:0]       done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_STATE;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    issue   = 1'b0;
    done    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (req_i[1]) begin
          sel_d   = SEL_KEY;
          last_d  = KEY_LAST;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else if (req_i[0]) begin
          sel_d   = SEL_STATE;
          last_d  = STATE_LAST;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rnd_valid_i) begin
          issue = 1'b1;
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == last_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Bytes leave in issue order, so the last index marks an empty pipe.
        if (wb_valid_o && (wb_idx_o == last_q)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = (sel_q == SEL_KEY) ? 2'b10 : 2'b01;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sbox_in_valid_o = issue;
  assign rnd_ready_o     = issue;
  assign sbox_in_idx_o   = issue ? cnt_q : '0;
  assign sbox_in_sel_o   = issue & sel_q;
  assign done_o          = done;
  assign busy_o          = (state_q != ST_IDLE);

  sbox_tag_pipe #(
    .LAT   (SBOX_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (issue),
    .in_idx_i    (sbox_in_idx_o),
    .in_sel_i    (sbox_in_sel_o),
    .out_valid_o (wb_valid_o),
    .out_idx_o   (wb_idx_o),
    .out_sel_o   (wb_sel_o)
  );

endmodule

// File: tb/tb_dom_sbox_scheduler.sv
// Directed bench for the S-box scheduler with a cycle-stamped scoreboard.
module tb_dom_sbox_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] req, done, req1, done1;
  logic       rnd, busy, rdy, iv, isel, wv, wsel;
  logic [3:0] iidx, widx;
  logic       rnd1, busy1, rdy1, iv1, isel1, wv1, wsel1;
  logic [3:0] iidx1, widx1;

  dom_sbox_scheduler #(.SBOX_LAT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .done_o(done), .busy_o(busy),
    .rnd_valid_i(rnd), .rnd_ready_o(rdy), .sbox_in_valid_o(iv),
    .sbox_in_idx_o(iidx), .sbox_in_sel_o(isel), .wb_valid_o(wv),
    .wb_idx_o(widx), .wb_sel_o(wsel)
  );

  dom_sbox_scheduler #(.SBOX_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_i(req1), .done_o(done1), .busy_o(busy1),
    .rnd_valid_i(rnd1), .rnd_ready_o(rdy1), .sbox_in_valid_o(iv1),
    .sbox_in_idx_o(iidx1), .sbox_in_sel_o(isel1), .wb_valid_o(wv1),
    .wb_idx_o(widx1), .wb_sel_o(wsel1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic sel; logic [3:0] idx; int cyc; } ev_t;
  typedef struct { logic [1:0] val; int cyc; } dn_t;
  ev_t exp_iss[$];
  ev_t exp_wb[$];
  dn_t exp_done[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic sel, input int n, input int t_iss0, input int lat);
    for (int i = 0; i < n; i++) begin
      exp_iss.push_back('{sel: sel, idx: 4'(i), cyc: t_iss0 + i});
      exp_wb.push_back('{sel: sel, idx: 4'(i), cyc: t_iss0 + lat + i});
    end
  endtask

  ev_t e;
  dn_t d;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("rdy_eq_iv", rdy, iv);
      if (rdy && !rnd) check("rdy_without_rnd", rdy, 0);
      if (iv) begin
        if (exp_iss.size() == 0) check("iss_unexpected", iv, 0);
        else begin
          e = exp_iss.pop_front();
          check("iss_idx", iidx, e.idx);
          check("iss_sel", isel, e.sel);
          check("iss_cyc", cyc, e.cyc);
        end
      end
      if (wv) begin
        if (exp_wb.size() == 0) check("wb_unexpected", wv, 0);
        else begin
          e = exp_wb.pop_front();
          check("wb_idx", widx, e.idx);
          check("wb_sel", wsel, e.sel);
          check("wb_cyc", cyc, e.cyc);
        end
      end
      if (done != 2'b00) begin
        if (exp_done.size() == 0) check("done_unexpected", done, 0);
        else begin
          d = exp_done.pop_front();
          check("done_val", done, d.val);
          check("done_cyc", cyc, d.cyc);
        end
      end
    end
  end

  int t0;

  initial begin
    rst_n = 1'b0; req = 2'b00; rnd = 1'b1; req1 = 2'b00; rnd1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_iv", iv, 0);
    check("rst_rdy", rdy, 0);
    check("rst_iidx", iidx, 0);
    check("rst_wv", wv, 0);
    check("rst_widx", widx, 0);
    rst_n = 1'b1;
    tick(); tick();

    // State request, no stalls, request dropped at cycle 3.
    tick(); t0 = cyc; req = 2'b01;
    push_op(1'b0, 16, t0 + 1, 4);
    exp_done.push_back('{val: 2'b01, cyc: t0 + 21});
    for (int k = 0; k <= 24; k++) begin
      if (k > 0) tick();
      if (k == 3) req = 2'b00;
      @(negedge clk);
      check("A_busy", busy, (k >= 1 && k <= 21));
    end
    tick();
    check("A_left", exp_iss.size() + exp_wb.size() + exp_done.size(), 0);

    // Both requests together: key first, then state from the next IDLE.
    tick(); t0 = cyc; req = 2'b11;
    push_op(1'b1, 4, t0 + 1, 4);
    exp_done.push_back('{val: 2'b10, cyc: t0 + 9});
    push_op(1'b0, 16, t0 + 11, 4);
    exp_done.push_back('{val: 2'b01, cyc: t0 + 31});
    for (int k = 0; k <= 34; k++) begin
      if (k > 0) tick();
      if (k == 2) req = 2'b01;
      if (k == 12) req = 2'b00;
      @(negedge clk);
      check("B_busy", busy, ((k >= 1 && k <= 9) || (k >= 11 && k <= 31)));
    end
    tick();
    check("B_left", exp_iss.size() + exp_wb.size() + exp_done.size(), 0);

    // Key request with randomness missing on cycles 2 and 3.
    tick(); t0 = cyc; req = 2'b10;
    exp_iss.push_back('{sel: 1'b1, idx: 4'd0, cyc: t0 + 1});
    exp_iss.push_back('{sel: 1'b1, idx: 4'd1, cyc: t0 + 4});
    exp_iss.push_back('{sel: 1'b1, idx: 4'd2, cyc: t0 + 5});
    exp_iss.push_back('{sel: 1'b1, idx: 4'd3, cyc: t0 + 6});
    exp_wb.push_back('{sel: 1'b1, idx: 4'd0, cyc: t0 + 5});
    exp_wb.push_back('{sel: 1'b1, idx: 4'd1, cyc: t0 + 8});
    exp_wb.push_back('{sel: 1'b1, idx: 4'd2, cyc: t0 + 9});
    exp_wb.push_back('{sel: 1'b1, idx: 4'd3, cyc: t0 + 10});
    exp_done.push_back('{val: 2'b10, cyc: t0 + 11});
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) tick();
      if (k == 1) req = 2'b00;
      if (k == 2) rnd = 1'b0;
      if (k == 4) rnd = 1'b1;
      @(negedge clk);
      check("C_busy", busy, (k >= 1 && k <= 11));
    end
    tick();
    check("C_left", exp_iss.size() + exp_wb.size() + exp_done.size(), 0);

    // Asynchronous reset at cycle 8 of a state operation.
    tick(); t0 = cyc; req = 2'b01;
    push_op(1'b0, 7, t0 + 1, 4);
    for (int i = 0; i < 4; i++) void'(exp_wb.pop_back());
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      if (k == 2) req = 2'b00;
      @(negedge clk);
    end
    tick();
    rst_n = 1'b0;
    #1;
    check("D_iv", iv, 0);
    check("D_rdy", rdy, 0);
    check("D_iidx", iidx, 0);
    check("D_wv", wv, 0);
    check("D_widx", widx, 0);
    check("D_busy", busy, 0);
    check("D_done", done, 0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      check("D_idle", busy, 0);
    end
    check("D_left", exp_iss.size() + exp_wb.size() + exp_done.size(), 0);

    // One-cycle S-box latency build.
    tick(); t0 = cyc; req1 = 2'b01;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      if (k == 2) req1 = 2'b00;
      @(negedge clk);
      check("E_iv", iv1, (k >= 1 && k <= 16));
      if (iv1) check("E_iidx", iidx1, k - 1);
      check("E_wv", wv1, (k >= 2 && k <= 17));
      if (wv1) check("E_widx", widx1, k - 2);
      check("E_done", done1, (k == 18) ? 2'b01 : 2'b00);
      check("E_busy", busy1, (k >= 1 && k <= 18));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
